seq_pattern_gen: RTL and testbench

//  Programmable pattern sequencer. Steps an index through a writable table of DEPTH

---
 rtl/seq_pattern_gen.sv | 147 ++++++++++++++
 tb/tb_seq_pattern_gen.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/seq_pattern_gen.sv
// Programmable pattern sequencer: walks an index through a writable word table
// in one-shot, loop, ping-pong or hold mode and presents the selected word on q.
module seq_pattern_gen #(
    parameter  int WIDTH = 4,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    len,
    input  logic [1:0]       mode,
    input  logic             start,
    input  logic             stop,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    output logic             busy,
    output logic             done,
    output logic [AW-1:0]    idx
);
    typedef enum logic [1:0] {IDLE, FWD, REV} state_t;

    localparam logic [1:0] M_ONESHOT = 2'b00;
    localparam logic [1:0] M_LOOP    = 2'b01;
    localparam logic [1:0] M_PINGPNG = 2'b10;

    state_t           r_state;
    logic [WIDTH-1:0] r_table [DEPTH];
    logic [WIDTH-1:0] r_q;
    logic [AW-1:0]    r_idx;
    logic [AW-1:0]    r_len;
    logic [1:0]       r_mode;
    logic             r_qv;
    logic             r_busy;
    logic             r_done;

    state_t           w_nstate;
    logic [AW-1:0]    w_nidx;
    logic [AW-1:0]    w_len_clamp;
    logic             w_load;
    logic             w_nqv;
    logic             w_ndone;
    logic             w_wr_ok;

    assign w_len_clamp = ({1'b0, len} > (AW+1)'(DEPTH-1)) ? AW'(DEPTH-1) : len;
    assign w_wr_ok     = wr_en && ({1'b0, wr_addr} < (AW+1)'(DEPTH));

    always_comb begin
        w_nstate = r_state;
        w_nidx   = r_idx;
        w_load   = 1'b0;
        w_nqv    = r_qv;
        w_ndone  = 1'b0;
        case (r_state)
            IDLE: begin
                if (start && !stop) begin
                    w_nstate = FWD;
                    w_nidx   = '0;
                    w_load   = 1'b1;
                    w_nqv    = 1'b1;
                end
            end
            FWD: begin
                if (stop) begin
                    w_nstate = IDLE;
                    w_nqv    = 1'b0;
                end else if (r_idx < r_len) begin
                    w_nidx = r_idx + AW'(1);
                    w_load = 1'b1;
                end else begin
                    case (r_mode)
                        M_ONESHOT: begin
                            w_nstate = IDLE;
                            w_nqv    = 1'b0;
                            w_ndone  = 1'b1;
                        end
                        M_LOOP: begin
                            w_nidx = '0;
                            w_load = 1'b1;
                        end
                        M_PINGPNG: begin
                            // a single-entry sequence has nothing to bounce off
                            if (r_len != '0) begin
                                w_nstate = REV;
                                w_nidx   = r_len - AW'(1);
                            end
                            w_load = 1'b1;
                        end
                        default: w_load = 1'b1;
                    endcase
                end
            end
            REV: begin
                if (stop) begin
                    w_nstate = IDLE;
                    w_nqv    = 1'b0;
                end else if (r_idx != '0) begin
                    w_nidx = r_idx - AW'(1);
                    w_load = 1'b1;
                end else begin
                    w_nstate = FWD;
                    w_nidx   = AW'(1);
                    w_load   = 1'b1;
                end
            end
            default: begin
                w_nstate = IDLE;
                w_nqv    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_q     <= '0;
            r_idx   <= '0;
            r_len   <= '0;
            r_mode  <= '0;
            r_qv    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) r_table[i] <= '0;
        end else begin
            if (w_wr_ok) r_table[wr_addr] <= wr_data;
            if (r_state == IDLE && start && !stop) begin
                r_len  <= w_len_clamp;
                r_mode <= mode;
            end
            r_state <= w_nstate;
            r_idx   <= w_nidx;
            r_qv    <= w_nqv;
            r_done  <= w_ndone;
            r_busy  <= (w_nstate != IDLE);
            // table read uses the pre-write word: same-cycle writes show next visit
            if (w_load) r_q <= r_table[w_nidx];
        end
    end

    assign q       = r_q;
    assign q_valid = r_qv;
    assign busy    = r_busy;
    assign done    = r_done;
    assign idx     = r_idx;
endmodule

// File: tb/tb_seq_pattern_gen.sv
// Directed bench for seq_pattern_gen: one linear stimulus sequence with
// hand-computed expectations checked by immediate assertions.
module tb_seq_pattern_gen;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [2:0] wr_addr = '0;
    logic [3:0] wr_data = '0;
    logic [2:0] len = '0;
    logic [1:0] mode = '0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [3:0] q;
    logic       q_valid, busy, done;
    logic [2:0] idx;

    int n_tests = 0;
    int n_fail  = 0;

    int tbl [8] = '{0, 1, 3, 7, 9, 13, 0, 15};
    int pp  [7] = '{0, 1, 2, 1, 0, 1, 2};
    int lp  [6] = '{0, 1, 3, 7, 0, 1};
    int hd  [6] = '{0, 1, 3, 7, 9, 9};

    seq_pattern_gen #(.WIDTH(4), .DEPTH(8)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .len(len), .mode(mode), .start(start), .stop(stop),
        .q(q), .q_valid(q_valid), .busy(busy), .done(done), .idx(idx)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic load_table();
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_addr = 3'(i); wr_data = 4'(tbl[i]);
            tick();
        end
        wr_en = 1'b0;
    endtask

    task automatic go(input logic [2:0] l, input logic [1:0] m);
        len = l; mode = m; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic halt();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    initial begin
        tick(); tick();
        rst = 1'b0;
        chk("rst_q", q, 0);
        chk("rst_qv", q_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_idx", idx, 0);

        load_table();

        // 1: one-shot over full table
        go(3'd7, 2'b00);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("os_q%0d", i), q, tbl[i]);
            chk($sformatf("os_qv%0d", i), q_valid, 1);
            chk($sformatf("os_done%0d", i), done, 0);
            tick();
        end
        chk("os_end_qv", q_valid, 0);
        chk("os_end_done", done, 1);
        chk("os_end_q", q, 15);
        chk("os_end_busy", busy, 0);
        tick();
        chk("os_done_pulse", done, 0);

        // 2: loop len=3, stop after 6 words
        go(3'd3, 2'b01);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("lp_q%0d", i), q, lp[i]);
            if (i < 5) tick();
        end
        halt();
        chk("lp_stop_qv", q_valid, 0);
        chk("lp_stop_busy", busy, 0);
        chk("lp_stop_q", q, 1);
        chk("lp_stop_done", done, 0);

        // 3: ping-pong len=2, then len=0
        go(3'd2, 2'b10);
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("pp_idx%0d", i), idx, pp[i]);
            chk($sformatf("pp_q%0d", i), q, tbl[pp[i]]);
            tick();
        end
        halt();
        go(3'd0, 2'b10);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("pp0_idx%0d", i), idx, 0);
            chk($sformatf("pp0_qv%0d", i), q_valid, 1);
            tick();
        end
        halt();

        // 4: hold len=4, start while busy ignored
        go(3'd4, 2'b11);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("hd_q%0d", i), q, hd[i]);
            tick();
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("hd_restart_idx", idx, 4);
        chk("hd_restart_q", q, 9);
        chk("hd_busy", busy, 1);
        chk("hd_done", done, 0);
        halt();
        chk("hd_stop_busy", busy, 0);
        chk("hd_stop_q", q, 9);

        // 5: start+stop in IDLE, then mid-run reset
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        chk("ss_busy", busy, 0);
        chk("ss_qv", q_valid, 0);
        go(3'd7, 2'b01);
        tick(); tick();
        chk("mid_q", q, 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_q", q, 0);
        chk("mrst_qv", q_valid, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_done", done, 0);
        chk("mrst_idx", idx, 0);
        go(3'd7, 2'b11);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("clr_q%0d", i), q, 0);
            chk($sformatf("clr_idx%0d", i), idx, i);
            tick();
        end
        halt();

        // 6: read-before-write on the word being loaded
        load_table();
        go(3'd3, 2'b01);
        chk("rbw_q0", q, 0);
        tick();
        chk("rbw_q1", q, 1);
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 4'd5;
        tick();
        wr_en = 1'b0;
        chk("rbw_old", q, 3);
        chk("rbw_idx", idx, 2);
        tick(); chk("rbw_q3", q, 7);
        tick(); chk("rbw_q0b", q, 0);
        tick(); chk("rbw_q1b", q, 1);
        tick(); chk("rbw_new", q, 5);
        halt();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
